// File: rtl/alsu_pkg.sv
// alsu_pkg: shared opcode encoding, LED patterns and the invalid-operation predicate
// for the ALSU slice.
// Macro ALSU_MULT_EN: when undefined, opcode 3 (MULT) is reported as invalid.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5
    } opcode_e;

    localparam logic [15:0] LED_ON  = 16'hFFFF;
    localparam logic [15:0] LED_OFF = 16'h0000;

    // Reduction is only meaningful for the bitwise ops; anything else with a
    // reduction flag, or an unused opcode, is an invalid request.
    function automatic logic is_invalid_op(input logic [2:0] op, input logic red);
        logic bad;
        bad = (op >= 3'd6) || (red && op > 3'd1);
`ifndef ALSU_MULT_EN
        bad = bad || (op == OP_MULT);
`endif
        return bad;
    endfunction

endpackage

// File: rtl/alsu_led_blinker.sv
// alsu_led_blinker: blinks all LEDs while the error flag is set.
// Ports: clk, rst_n (async active-low), err (sticky error flag),
//        restart (an invalid request completes this cycle), leds (16-bit pattern).
// leds show LED_ON for DIV cycles, then LED_OFF for DIV cycles, repeating,
// starting with LED_ON on the first cycle err is high after a restart.
module alsu_led_blinker
    import alsu_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        err,
    input  logic        restart,
    output logic [15:0] leds
);

    logic [15:0] cnt;
    logic        phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (err) begin
            if (cnt == 16'(DIV - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign leds = (err && !phase) ? LED_ON : LED_OFF;

endmodule

// File: rtl/alsu_param.sv
// alsu_param: two-stage pipelined arithmetic/logic/shift unit with sticky error
// flag and blinking error LEDs.
// Ports: CLK, RST_n (async active-low), in_valid, A, B, opcode, cin, serial_in,
//        direction (1 = left), red_op_A, red_op_B, bypass_A, bypass_B ->
//        out (2*WIDTH, registered), out_valid (pulse), err (sticky), leds (16).
// Macro ALSU_MULT_EN: defined enables opcode 3 (MULT); undefined makes it invalid
// and builds no multiplier.
module alsu_param
    import alsu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int BLINK_DIV      = 4
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         opcode,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               err,
    output logic [15:0]        leds
);

    localparam int OW    = 2 * WIDTH;
    localparam bit PRI_A = (INPUT_PRIORITY == "A");
    localparam bit USE_C = (FULL_ADDER == "ON");

    logic             v1;
    logic [WIDTH-1:0] a1, b1;
    opcode_e          op1;
    logic             cin1, sin1, dir1, ra1, rb1, ba1, bb1;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            op1  <= OP_AND;
            cin1 <= 1'b0;
            sin1 <= 1'b0;
            dir1 <= 1'b0;
            ra1  <= 1'b0;
            rb1  <= 1'b0;
            ba1  <= 1'b0;
            bb1  <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1   <= A;
                b1   <= B;
                op1  <= opcode_e'(opcode);
                cin1 <= cin;
                sin1 <= serial_in;
                dir1 <= direction;
                ra1  <= red_op_A;
                rb1  <= red_op_B;
                ba1  <= bypass_A;
                bb1  <= bypass_B;
            end
        end
    end

    logic             byp, inv;
    logic [WIDTH-1:0] pri_opd, byp_opd, red_opd, low;
    logic [WIDTH:0]   sum;
    logic [OW-1:0]    res;

    // The same priority operand resolves both the bypass and the reduction tie.
    assign pri_opd = PRI_A ? a1 : b1;
    assign byp     = ba1 || bb1;
    assign byp_opd = (ba1 && bb1) ? pri_opd : (ba1 ? a1 : b1);
    assign red_opd = (ra1 && rb1) ? pri_opd : (ra1 ? a1 : b1);
    assign inv     = !byp && is_invalid_op(op1, ra1 || rb1);
    assign sum     = (WIDTH+1)'(a1) + (WIDTH+1)'(b1) + (WIDTH+1)'(USE_C && cin1);
    // Shift/rotate work on the low half of the currently held result.
    assign low     = out[WIDTH-1:0];

    always_comb begin
        res = '0;
        if (byp) begin
            res = OW'(byp_opd);
        end else if (!inv) begin
            case (op1)
                OP_AND:    res = (ra1 || rb1) ? OW'(&red_opd) : OW'(a1 & b1);
                OP_XOR:    res = (ra1 || rb1) ? OW'(^red_opd) : OW'(a1 ^ b1);
                OP_ADD:    res = OW'(sum);
`ifdef ALSU_MULT_EN
                OP_MULT:   res = OW'(a1) * OW'(b1);
`endif
                OP_SHIFT:  res = OW'(dir1 ? {low[WIDTH-2:0], sin1} : {sin1, low[WIDTH-1:1]});
                OP_ROTATE: res = OW'(dir1 ? {low[WIDTH-2:0], low[WIDTH-1]} : {low[0], low[WIDTH-1:1]});
                default:   res = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out <= res;
                err <= inv;
            end
        end
    end

    alsu_led_blinker #(
        .DIV(BLINK_DIV)
    ) u_blink (
        .clk    (CLK),
        .rst_n  (RST_n),
        .err    (err),
        .restart(v1 && inv),
        .leds   (leds)
    );

endmodule

// File: tb/tb_alsu_param.sv
// tb_alsu_param: randomized + directed bench for alsu_param (WIDTH=8, BLINK_DIV=4)
// against a behavioural reference model.
module tb_alsu_param;

    localparam int DIV = 4;
`ifdef ALSU_MULT_EN
    localparam bit MULT = 1'b1;
`else
    localparam bit MULT = 1'b0;
`endif

    logic        CLK = 1'b0, RST_n = 1'b0, in_valid = 1'b0;
    logic [7:0]  A = '0, B = '0;
    logic [2:0]  opcode = '0;
    logic        cin = 0, serial_in = 0, direction = 0, red_op_A = 0, red_op_B = 0;
    logic        bypass_A = 0, bypass_B = 0;
    logic [15:0] out, leds;
    logic        out_valid, err;

    int n_tests = 0, n_fail = 0;

    alsu_param #(.WIDTH(8), .BLINK_DIV(DIV)) dut (
        .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
        .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out(out), .out_valid(out_valid), .err(err), .leds(leds)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int a, b, op;
        bit cin, sin, dir, ra, rb, ba, bb;
    } req_t;

    function automatic bit m_inv(req_t r);
        if (r.ba || r.bb) return 1'b0;
        if (r.op >= 6) return 1'b1;
        if (r.op == 3 && !MULT) return 1'b1;
        return (r.ra || r.rb) && r.op > 1;
    endfunction

    function automatic logic [15:0] m_res(req_t r, logic [15:0] prev);
        int x, opd;
        x = int'(prev[7:0]);
        if (r.ba || r.bb) return 16'(r.ba ? r.a : r.b);
        if (m_inv(r)) return 16'd0;
        opd = r.ra ? r.a : r.b;
        case (r.op)
            0: return 16'((r.ra || r.rb) ? int'(opd == 255) : (r.a & r.b));
            1: return 16'((r.ra || r.rb) ? ($countones(opd) % 2) : (r.a ^ r.b));
            2: return 16'(r.a + r.b + int'(r.cin));
            3: return 16'(r.a * r.b);
            4: return 16'(r.dir ? ((x * 2) % 256 + int'(r.sin)) : (x / 2 + int'(r.sin) * 128));
            default: return 16'(r.dir ? ((x * 2) % 256 + x / 128) : (x / 2 + (x % 2) * 128));
        endcase
    endfunction

    function automatic req_t cur_req();
        req_t r;
        r.a = int'(A); r.b = int'(B); r.op = int'(opcode);
        r.cin = cin; r.sin = serial_in; r.dir = direction;
        r.ra = red_op_A; r.rb = red_op_B; r.ba = bypass_A; r.bb = bypass_B;
        return r;
    endfunction

    function automatic req_t mk(int a, int b, int op, bit c, bit s, bit d,
                                bit ra, bit rb, bit ba, bit bb);
        req_t r;
        r.a = a; r.b = b; r.op = op; r.cin = c; r.sin = s; r.dir = d;
        r.ra = ra; r.rb = rb; r.ba = ba; r.bb = bb;
        return r;
    endfunction

    // Reference model: one pending request, the held result, and the number of
    // cycles since the most recent invalid request completed.
    req_t        p_req;
    bit          p_v, m_ov, m_err;
    logic [15:0] m_out;
    int          since;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            p_v   <= 1'b0;
            m_ov  <= 1'b0;
            m_err <= 1'b0;
            m_out <= '0;
            since <= 0;
        end else begin
            m_ov <= p_v;
            if (p_v) begin
                m_out <= m_res(p_req, m_out);
                m_err <= m_inv(p_req);
            end
            since <= (p_v && m_inv(p_req)) ? 0 : since + 1;
            p_v <= in_valid;
            if (in_valid) p_req <= cur_req();
        end
    end

    function automatic logic [15:0] m_leds();
        if (!m_err) return 16'h0000;
        return ((since / DIV) % 2 == 1) ? 16'h0000 : 16'hFFFF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            check("model_out", 32'(out), 32'(m_out));
            check("model_out_valid", 32'(out_valid), 32'(m_ov));
            check("model_err", 32'(err), 32'(m_err));
            check("model_leds", 32'(leds), 32'(m_leds()));
        end
    end

    task automatic drive(req_t r);
        A = 8'(r.a); B = 8'(r.b); opcode = 3'(r.op);
        cin = r.cin; serial_in = r.sin; direction = r.dir;
        red_op_A = r.ra; red_op_B = r.rb; bypass_A = r.ba; bypass_B = r.bb;
    endtask

    // One request; checks out_valid stays low one cycle then pulses with exp.
    task automatic run(input string name, input req_t r, input logic [15:0] exp);
        @(posedge CLK); #1;
        drive(r);
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check({name, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge CLK);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_out"}, 32'(out), 32'(exp));
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        @(posedge CLK); #2;
        RST_n = 1'b1;

        run("add", mk(200, 100, 2, 1, 0, 0, 0, 0, 0, 0), 16'd301);
        check("add_err", 32'(err), 32'd0);

        run("mult", mk(255, 255, 3, 0, 0, 0, 0, 0, 0, 0), MULT ? 16'd65025 : 16'd0);
        check("mult_err", 32'(err), 32'(!MULT));

        run("inv6", mk(1, 2, 6, 0, 0, 0, 0, 0, 0, 0), 16'd0);
        check("inv6_err", 32'(err), 32'd1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge CLK);
            check("blink", 32'(leds), ((k / 4) % 2 == 1) ? 32'h0000 : 32'hFFFF);
        end
        run("and", mk(8'h0F, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0), 16'h000C);
        check("and_err", 32'(err), 32'd0);
        check("and_leds", 32'(leds), 32'd0);

        run("byp_inv", mk(8'h5A, 8'hA5, 7, 0, 0, 0, 0, 0, 1, 1), 16'h005A);
        check("byp_err", 32'(err), 32'd0);

        run("load81", mk(8'h81, 0, 0, 0, 0, 0, 0, 0, 1, 0), 16'h0081);
        run("shl", mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0), 16'h0003);
        run("rotr", mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0), 16'h0081);
        run("xor_red", mk(8'h07, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0), 16'h0001);

        repeat (800) begin
            @(posedge CLK); #1;
            drive(mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0));
            in_valid = ($urandom_range(0, 3) != 0);
        end

        in_valid = 1'b1;
        drive(mk(3, 4, 2, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #3;
        RST_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_leds", 32'(leds), 32'd0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        #1;
        RST_n = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("no_ghost_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alsu_param.md
ALSU_PARAM -- requirements
Module: alsu_param

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 3..16.
REQ-002 Parameter INPUT_PRIORITY, default "A", operand that wins when both bypass or both reduction flags are set ("A" or "B").
REQ-003 Parameter FULL_ADDER, default "ON", "ON" adds cin into ADD; "OFF" ignores cin.
REQ-004 Parameter BLINK_DIV, default 4, cycles per LED toggle while in error; minimum 1.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  operation request; sampled every cycle, no backpressure.
REQ-008 A, B  in  WIDTH  operands.
REQ-009 opcode  in  3  0 AND, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6-7 invalid.
REQ-010 cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  operation modifiers; direction 1 = left.
REQ-011 out  out  2*WIDTH  registered result.
REQ-012 out_valid  out  1  one-cycle pulse per completed request.
REQ-013 err  out  1  sticky invalid-operation flag.
REQ-014 leds  out  16  error indicator.

Function
REQ-015 Stage 1 SHALL register all inputs when in_valid=1; stage 2 SHALL register out and out_valid one cycle later; latency 2 cycles, throughput 1 per cycle, back-to-back allowed.
REQ-016 Without an accepted request, out and err SHALL hold and out_valid SHALL be 0.
REQ-017 Precedence, highest first: bypass, invalid, opcode.
REQ-018 Bypass: single flag selects that operand; both set selects INPUT_PRIORITY operand; result zero-extended; err cleared.
REQ-019 Invalid: opcode 6/7, or any red_op flag with opcode not 0/1; out SHALL be 0, err SHALL be 1.
REQ-020 AND/XOR: bitwise A op B; red_op_A or red_op_B alone reduces that operand to 1 bit; both set reduces the INPUT_PRIORITY operand.
REQ-021 ADD: A+B(+cin when FULL_ADDER="ON"), WIDTH+1-bit result, zero-extended.
REQ-022 MULT: unsigned A*B, full 2*WIDTH bits.
REQ-023 SHIFT/ROTATE SHALL operate on out[WIDTH-1:0] as held at that stage-2 update, upper WIDTH bits forced 0; SHIFT left {x[W-2:0],serial_in}, right {serial_in,x[W-1:1]}; ROTATE left {x[W-2:0],x[W-1]}, right {x[0],x[W-1:1]}.
REQ-024 Any accepted valid operation (including bypass) SHALL clear err.
REQ-025 While err=1, leds SHALL alternate 16'hFFFF / 16'h0000 every BLINK_DIV cycles, starting 16'hFFFF on the cycle err rises; blink counter SHALL restart on each new invalid request; leds SHALL be 0 while err=0.

Reset
REQ-026 RST_n low SHALL immediately clear out, out_valid, err, leds, stage-1 valid and blink counter; in-flight requests are discarded, none SHALL complete after release.

Configuration
REQ-027 Macro ALSU_MULT_EN defined: opcode 3 multiplies per REQ-022.
REQ-028 ALSU_MULT_EN undefined: opcode 3 SHALL be invalid per REQ-019 and no multiplier SHALL be synthesised.

Structure
REQ-029 Package alsu_pkg SHALL hold the opcode enum, the LED pattern constants and the invalid-opcode predicate function.
REQ-030 LED blink counter SHALL be sub-module alsu_led_blinker (inputs err, restart; output leds).

Verification (WIDTH=8, BLINK_DIV=4)
REQ-031 RST_n=0 mid-stream -> out=0, out_valid=0, err=0, leds=0 at once; no out_valid after release.
REQ-032 ADD A=200,B=100,cin=1 -> out=301 with out_valid pulse 2 cycles after in_valid; FULL_ADDER="OFF" -> 300.
REQ-033 MULT A=255,B=255 -> out=65025 with ALSU_MULT_EN; without it err=1, out=0, leds blink.
REQ-034 opcode=6 -> err=1, leds FFFF 4 cycles, 0000 4 cycles, repeating; next AND A=0x0F,B=0x3C -> out=0x0C, err=0, leds=0.
REQ-035 bypass_A=bypass_B=1 with opcode=7, A=0x5A, B=0xA5, INPUT_PRIORITY="A" -> out=0x5A, err=0.
REQ-036 out=0x81 then SHIFT left serial_in=1 -> 0x03; then ROTATE right -> 0x81.
